// File: rtl/tap_result_arbiter.sv
// tap_result_arbiter: round-robin sharing of the JTAG user-DR result encoder between NUM_REQ producers.
// A granted result is held until the host completes a user-DR capture followed by an update.
module tap_result_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_WIDTH = 16,
    localparam int TAG_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                               tck,
    input  logic                               test_logic_reset,
    input  logic                               ir_is_user,
    input  logic                               capture_dr,
    input  logic                               update_dr,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [1+TAG_WIDTH+DATA_WIDTH-1:0]  enc_data,
    output logic                               enc_valid,
    output logic                               busy
);
    typedef enum logic [2:0] {IDLE, GRANT, WAIT_CAP, WAIT_UPD, CLEAR} state_t;

    state_t                            state_q, state_d;
    logic [1+TAG_WIDTH+DATA_WIDTH-1:0] frame_q, frame_d;
    logic [TAG_WIDTH-1:0]              last_q, last_d;
    logic [TAG_WIDTH-1:0]              sel;
    logic [DATA_WIDTH-1:0]             sel_data;
    int                                best;

    // The valid requester with the smallest distance past last wins.
    always_comb begin
        best = NUM_REQ;
        sel = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && ((i + NUM_REQ - 1 - int'(last_q)) % NUM_REQ) < best) begin
                best = (i + NUM_REQ - 1 - int'(last_q)) % NUM_REQ;
                sel = TAG_WIDTH'(i);
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        last_d = last_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                state_d = GRANT;
                frame_d = {1'b1, sel, sel_data};
                last_d = sel;
            end
            GRANT: state_d = WAIT_CAP;
            WAIT_CAP: state_d = (ir_is_user && capture_dr) ? WAIT_UPD : WAIT_CAP;
            // Frame is cleared on entry so the CLEAR cycle already shows a zero word.
            WAIT_UPD: if (ir_is_user && update_dr) begin
                state_d = CLEAR;
                frame_d = '0;
            end
            CLEAR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tck) begin
        if (test_logic_reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            last_q <= TAG_WIDTH'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = (state_q == GRANT) && (frame_q[DATA_WIDTH +: TAG_WIDTH] == TAG_WIDTH'(i));
    end

    assign enc_data = frame_q;
    assign enc_valid = (state_q == GRANT) || (state_q == CLEAR);
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_tap_result_arbiter.sv
// tb_tap_result_arbiter: directed checks of grant order, host-read handshake, ignored accesses and reset abort.
module tb_tap_result_arbiter;
    logic        tck = 1'b0;
    logic        test_logic_reset = 1'b1;
    logic        ir_is_user = 1'b0;
    logic        capture_dr = 1'b0;
    logic        update_dr = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [31:0] req_data = {16'hBEEF, 16'h1234};
    logic [1:0]  req_ready;
    logic [17:0] enc_data;
    logic        enc_valid;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    tap_result_arbiter #(.NUM_REQ(2), .DATA_WIDTH(16)) dut (
        .tck(tck),
        .test_logic_reset(test_logic_reset),
        .ir_is_user(ir_is_user),
        .capture_dr(capture_dr),
        .update_dr(update_dr),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .enc_data(enc_data),
        .enc_valid(enc_valid),
        .busy(busy)
    );

    always #5 tck = ~tck;

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expects the next edge to grant; walks one full host read and returns in IDLE.
    task automatic host_read(input string tag, input logic [1:0] rdy, input logic [17:0] word);
        step();
        chk({tag, "_ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, "_word"}, 32'(enc_data), 32'(word));
        chk({tag, "_valid"}, 32'(enc_valid), 32'd1);
        step();
        ir_is_user = 1'b1;
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        update_dr = 1'b1;
        step();
        chk({tag, "_clr_valid"}, 32'(enc_valid), 32'd1);
        chk({tag, "_clr_word"}, 32'(enc_data), 32'd0);
        update_dr = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word", 32'(enc_data), 32'd0);
        chk("rst_valid", 32'(enc_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        test_logic_reset = 1'b0;
        req_valid = 2'b01;
        step();
        chk("g0_ready", 32'(req_ready), 32'h1);
        chk("g0_valid", 32'(enc_valid), 32'd1);
        chk("g0_word", 32'(enc_data), 32'h21234);
        chk("g0_busy", 32'(busy), 32'd1);
        req_valid = 2'b00;
        step();
        chk("wc_ready", 32'(req_ready), 32'h0);
        chk("wc_valid", 32'(enc_valid), 32'd0);
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        update_dr = 1'b1;
        step();
        ir_is_user = 1'b1;
        step();
        update_dr = 1'b0;
        chk("nouser_word", 32'(enc_data), 32'h21234);
        chk("nouser_valid", 32'(enc_valid), 32'd0);
        chk("nouser_busy", 32'(busy), 32'd1);
        capture_dr = 1'b1;
        step();
        step();
        capture_dr = 1'b0;
        chk("recap_word", 32'(enc_data), 32'h21234);
        chk("recap_valid", 32'(enc_valid), 32'd0);
        update_dr = 1'b1;
        step();
        update_dr = 1'b0;
        chk("clr_valid", 32'(enc_valid), 32'd1);
        chk("clr_word", 32'(enc_data), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(enc_valid), 32'd0);
        step();
        chk("noextra_busy", 32'(busy), 32'd0);
        chk("noextra_ready", 32'(req_ready), 32'h0);
        test_logic_reset = 1'b1;
        step();
        test_logic_reset = 1'b0;
        req_valid = 2'b11;
        host_read("rr0", 2'b01, 18'h21234);
        host_read("rr1", 2'b10, 18'h3BEEF);
        host_read("rr2", 2'b01, 18'h21234);
        host_read("rr3", 2'b10, 18'h3BEEF);
        step();
        chk("ab_grant", 32'(req_ready), 32'h1);
        step();
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        chk("ab_wu_word", 32'(enc_data), 32'h21234);
        test_logic_reset = 1'b1;
        step();
        chk("ab_word", 32'(enc_data), 32'd0);
        chk("ab_valid", 32'(enc_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_ready", 32'(req_ready), 32'h0);
        test_logic_reset = 1'b0;
        step();
        chk("post_ready", 32'(req_ready), 32'h1);
        chk("post_word", 32'(enc_data), 32'h21234);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tap_result_arbiter.md
Name: tap_result_arbiter

Overview:
- Shares the single JTAG user-DR result encoder between NUM_REQ result producers.
- Picks one pending result round-robin, tags it with the requester index and presents it to the encoder.
- Holds the result until the host has completed a full user-DR read (capture then update), then clears the encoder word and serves the next requester.
- Sits between the puzzle solver cores and the tap encoder, in the tck domain.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- DATA_WIDTH, 16, result width per requester.
- TAG_WIDTH, $clog2(NUM_REQ), derived; requester index width, not to be overridden.

Ports:
- tck  input  1  JTAG TCK, sole clock.
- test_logic_reset  input  1  reset, synchronous and active-high.
- ir_is_user  input  1  USER instruction selected.
- capture_dr  input  1  TAP in Capture-DR.
- update_dr  input  1  TAP in Update-DR.
- req_valid  input  NUM_REQ  per-requester result pending.
- req_data  input  NUM_REQ*DATA_WIDTH  results; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot acceptance pulse.
- enc_data  output  1+TAG_WIDTH+DATA_WIDTH  encoder word {present, tag, data}.
- enc_valid  output  1  one-cycle load strobe to the encoder.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, high, dominates all other inputs):
  - state <= IDLE; frame register <= 0; req_ready = 0; enc_valid = 0; enc_data = 0; busy = 0.
  - Round-robin pointer last <= NUM_REQ-1, so requester 0 wins first.
  - A result already accepted but not yet read is dropped.
- Requester contract: once req_valid[i] rises, it holds req_valid[i] and its data slice stable until the cycle req_ready[i]=1. The transfer happens in that cycle.
- States:
  - IDLE: if any req_valid, select g = first requester set at or after (last+1) mod NUM_REQ, wrapping. At the same edge latch frame <= {1'b1, g, req_data[g]}, set last <= g, go to GRANT. Otherwise stay.
  - GRANT (exactly 1 cycle): req_ready[g]=1, enc_valid=1, enc_data=frame. Go to WAIT_CAP.
  - WAIT_CAP: wait for ir_is_user && capture_dr, then go to WAIT_UPD. update_dr is ignored here. A capture during the GRANT cycle itself does not count.
  - WAIT_UPD: on ir_is_user && update_dr, go to CLEAR. A repeated capture_dr (host re-read without update) keeps the state. test_logic_reset still aborts.
  - CLEAR (exactly 1 cycle): frame <= 0, enc_valid=1, enc_data=0. Go to IDLE.
- enc_data equals frame at all times. It is stable from GRANT through WAIT_UPD, and 0 in CLEAR and IDLE.
- req_ready and enc_valid are registered (decoded from state); there is no combinational path from inputs.
- Latency: req_valid sampled in IDLE leads to req_ready/enc_valid one cycle later. The minimum gap between two grants is GRANT + capture + update + CLEAR + IDLE.
- Any capture/update with ir_is_user=0 is ignored in all states.
- A requester that drops req_valid while not granted is simply skipped (contract violation, no error flag).
- Requester set rising during GRANT through CLEAR waits for the next IDLE evaluation.

Test Plan:
- Reset then req_valid=2'b01, req_data[0]=16'h1234 -> req_ready=2'b01 one cycle later, same cycle enc_valid=1, enc_data=18'h21234, busy=1.
- After that grant: capture_dr then update_dr with ir_is_user=1 -> CLEAR cycle with enc_valid=1, enc_data=0, then IDLE, busy=0.
- Both requesters continuously valid (16'h1234, 16'hBEEF), four complete host reads -> grant order 0,1,0,1; words 18'h21234, 18'h3BEEF alternating.
- capture_dr and update_dr pulsed with ir_is_user=0 while in WAIT_CAP -> state, enc_data=18'h21234 unchanged, no CLEAR.
- Capture, second capture, then update -> exactly one CLEAR after the update; no extra grant.
- test_logic_reset asserted in WAIT_UPD -> next cycle enc_data=0, enc_valid=0, busy=0. The next grant with both requesters valid goes to requester 0.
